// File: rtl/tm_mac_ctrl.sv
// tm_mac_ctrl: streams (A, W) operand pairs through an external mixed-sign
// multiplier and accumulates the products into a dot product.
//   Stage 1: an accepted beat is registered onto mul_a/mul_w.
//   Stage 2: the multiplier result mul_q is added into acc.
// Optional feature macro: TM_MAC_SAT_EN (saturating accumulation with a
// sticky out_sat flag). Without it the accumulator wraps and out_sat is 0.
module tm_mac_ctrl #(
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_asigned,
  input  logic             cfg_wsigned,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_w,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0] out_count,
  output logic             out_sat,
  output logic [DW-1:0]    mul_a,
  output logic             mul_asigned,
  output logic [DW-1:0]    mul_w,
  output logic             mul_wsigned,
  input  logic [2*DW:0]    mul_q,
  output logic             busy
);

  localparam int PW    = 2 * DW + 1;
  // Common width wide enough to hold both the accumulator and a product.
  localparam int EXT_W = (ACC_W > PW) ? ACC_W : PW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state;
  logic             prod_valid;
  logic             prod_last;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic [ACC_W-1:0] acc_next;
  logic             in_fire;

  // Ready decodes registered state only; rst_n gating keeps it low while
  // reset is held so that every output reads 0 during reset.
  assign in_ready = rst_n && ((state == IDLE) ||
                              ((state == ACC) && !(prod_valid && prod_last)));
  assign in_fire  = in_valid && in_ready;

  assign out_acc   = acc;
  assign out_count = count;
  assign busy      = (state != IDLE) || prod_valid;

`ifdef TM_MAC_SAT_EN
  localparam int SUM_W = EXT_W + 1;

  logic signed [SUM_W-1:0]     sum;
  logic        [SUM_W-ACC_W:0] sum_hi;
  logic                        sat_hit;
  logic                        sat;

  // Saturating add: one guard bit above the operands; overflow is any
  // disagreement among the bits at and above the accumulator's sign bit.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    sum      = SUM_W'($signed(acc)) + SUM_W'($signed(mul_q));
    sum_hi   = sum[SUM_W-1:ACC_W-1];
    sat_hit  = !((&sum_hi) || !(|sum_hi));
    acc_next = sum[ACC_W-1:0];
    if (sat_hit) begin
      acc_next = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign out_sat = sat;
`else
  logic [EXT_W-1:0] sum;

  // Wrapping add: product sign-extended, result taken modulo 2^ACC_W.
  always_comb begin
    sum      = EXT_W'($signed(acc)) + EXT_W'($signed(mul_q));
    acc_next = sum[ACC_W-1:0];
  end

  assign out_sat = 1'b0;
`endif

  // Controller FSM together with both pipeline stages and registered outputs.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prod_valid  <= 1'b0;
      prod_last   <= 1'b0;
      acc         <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      mul_a       <= '0;
      mul_w       <= '0;
      mul_asigned <= 1'b0;
      mul_wsigned <= 1'b0;
`ifdef TM_MAC_SAT_EN
      sat         <= 1'b0;
`endif
    end else begin
      // Stage 1: register the accepted beat onto the multiplier operands.
      if (in_fire) begin
        mul_a      <= in_a;
        mul_w      <= in_w;
        prod_valid <= 1'b1;
        prod_last  <= in_last;
        count      <= count + 1'b1;
      end else begin
        prod_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Sign modes are fixed for the vector by its first beat.
          if (in_fire) begin
            mul_asigned <= cfg_asigned;
            mul_wsigned <= cfg_wsigned;
            state       <= ACC;
          end
        end
        ACC: begin
          // Stage 2: fold the product in flight into the accumulator.
          if (prod_valid) begin
            acc <= acc_next;
`ifdef TM_MAC_SAT_EN
            sat <= sat || sat_hit;
`endif
            if (prod_last) begin
              state     <= OUT;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          // Result held stable until the sink takes it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
`ifdef TM_MAC_SAT_EN
            sat       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
